// File: rtl/seg_disp_pkg.sv
// Shared glyph codes and active-low {g..a} segment patterns for the
// multiplexed seven-segment display driver.
package seg_disp_pkg;

    typedef logic [4:0] glyph_t;
    typedef logic [6:0] seg_t;

    localparam glyph_t GLYPH_BLANK = 5'h10;
    localparam glyph_t GLYPH_MINUS = 5'h11;
    localparam glyph_t GLYPH_UNDER = 5'h12;
    localparam glyph_t GLYPH_DEG   = 5'h13;

    localparam seg_t SEG_OFF   = 7'h7F;
    localparam seg_t SEG_MINUS = 7'h3F;
    localparam seg_t SEG_UNDER = 7'h77;
    localparam seg_t SEG_DEG   = 7'h1C;

    // Hex font, entry 0 in the low slice; a cleared bit lights that segment.
    localparam logic [15:0][6:0] HEX_PATTERNS = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

endpackage

// File: rtl/seg_glyph_decode.sv
// Combinational glyph decoder: 5-bit glyph code to active-low {g..a} pattern.
module seg_glyph_decode
    import seg_disp_pkg::*;
(
    input  logic [4:0] code,
    output logic [6:0] pattern
);

    always_comb begin
        pattern = SEG_OFF;
        if (!code[4]) begin
            pattern = HEX_PATTERNS[code[3:0]];
        end else begin
            case (code)
                GLYPH_MINUS: pattern = SEG_MINUS;
                GLYPH_UNDER: pattern = SEG_UNDER;
                GLYPH_DEG:   pattern = SEG_DEG;
                default:     pattern = SEG_OFF;
            endcase
        end
    end

endmodule

// File: rtl/seg_display_mux.sv
// Time-multiplexed seven-segment driver: per-digit slots split into 16
// brightness subslots, frame-coherent shadow registers, dead-time anti-ghosting.
module seg_display_mux
    import seg_disp_pkg::*;
#(
    parameter int NUM_DIGITS  = 8,
    parameter int REFRESH_DIV = 100000,
    parameter int DEAD_CYC    = 2,
    parameter int SIMULATE    = 0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_DIGITS*5-1:0] digits,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   blank_mask,
    input  logic [3:0]              brightness,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [3:0]              digit_idx,
    output logic                    frame_done
);

    localparam int REFRESH_EFF = (SIMULATE != 0) ? 32 : REFRESH_DIV;
    localparam int SUB_CYC     = REFRESH_EFF / 16;
    localparam int CW          = (SUB_CYC > 1) ? $clog2(SUB_CYC) : 1;
    localparam logic [CW-1:0] CYC_LAST = CW'(SUB_CYC - 1);
    localparam logic [3:0]    IDX_LAST = 4'(NUM_DIGITS - 1);

    if (REFRESH_DIV % 16 != 0) begin : g_bad_refresh_div
        $error("seg_display_mux: REFRESH_DIV must be a multiple of 16");
    end
    if (DEAD_CYC < 0 || DEAD_CYC >= REFRESH_DIV / 16) begin : g_bad_dead_cyc
        $error("seg_display_mux: DEAD_CYC must be below REFRESH_DIV/16");
    end
    if (NUM_DIGITS < 1 || NUM_DIGITS > 16) begin : g_bad_num_digits
        $error("seg_display_mux: NUM_DIGITS must be in 1..16");
    end

    logic [CW-1:0] cyc_cnt, cyc_nxt;
    logic [3:0]    sub_cnt, sub_nxt;
    logic [3:0]    idx_nxt;
    logic [3:0]    bright_q, bright_nxt;
    logic          sub_end, slot_end, frame_end;
    logic          capture_pending;
    logic          an_on;
    logic [NUM_DIGITS-1:0] an_nxt;

    logic [NUM_DIGITS*5-1:0] shadow_codes;
    logic [NUM_DIGITS-1:0]   shadow_dp;
    logic [NUM_DIGITS-1:0]   shadow_blank;

    logic [4:0] cur_code;
    logic       cur_dp;
    logic       cur_blank;
    logic [6:0] glyph_pat;

    seg_glyph_decode u_decode (
        .code    (cur_code),
        .pattern (glyph_pat)
    );

    always_comb begin
        sub_end   = (cyc_cnt == CYC_LAST);
        slot_end  = sub_end && (sub_cnt == 4'd15);
        frame_end = slot_end && (digit_idx == IDX_LAST);

        cyc_nxt = sub_end ? '0 : cyc_cnt + CW'(1);
        sub_nxt = sub_end ? sub_cnt + 4'd1 : sub_cnt;
        idx_nxt = digit_idx;
        if (slot_end) begin
            idx_nxt = frame_end ? 4'd0 : digit_idx + 4'd1;
        end
        bright_nxt = slot_end ? brightness : bright_q;

        // Anode is registered from next-cycle counters so it lines up with the slot position.
        an_on = (sub_nxt <= bright_nxt) &&
                (int'(sub_nxt) * SUB_CYC + int'(cyc_nxt) >= DEAD_CYC);

        an_nxt    = '1;
        cur_code  = GLYPH_BLANK;
        cur_dp    = 1'b0;
        cur_blank = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_nxt == 4'(i) && an_on) begin
                an_nxt[i] = 1'b0;
            end
            if (digit_idx == 4'(i)) begin
                cur_code  = shadow_codes[i*5 +: 5];
                cur_dp    = shadow_dp[i];
                cur_blank = shadow_blank[i];
            end
        end
    end

    // NOTE: the shadow bank is reset on purpose: a display lit from
    // uninitialised registers would flash garbage before the first capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            cyc_cnt         <= '0;
            sub_cnt         <= '0;
            digit_idx       <= '0;
            bright_q        <= brightness;
            capture_pending <= 1'b1;
            shadow_codes    <= {NUM_DIGITS{GLYPH_BLANK}};
            shadow_dp       <= '0;
            shadow_blank    <= '1;
            seg             <= SEG_OFF;
            dp              <= 1'b1;
            an              <= '1;
            frame_done      <= 1'b0;
        end else begin
            cyc_cnt         <= cyc_nxt;
            sub_cnt         <= sub_nxt;
            digit_idx       <= idx_nxt;
            bright_q        <= bright_nxt;
            capture_pending <= 1'b0;
            if (capture_pending || frame_end) begin
                shadow_codes <= digits;
                shadow_dp    <= dp_in;
                shadow_blank <= blank_mask;
            end
            seg        <= cur_blank ? SEG_OFF : glyph_pat;
            dp         <= cur_blank | ~cur_dp;
            an         <= an_nxt;
            frame_done <= frame_end;
        end
    end

endmodule
